// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed hex display driver for a common-anode seven-segment panel.
// Captures a 32-bit value on load and scans one nibble per DIV-cycle slot, with optional leading-zero blanking.
module seg_scan_driver #(
  parameter int DIV = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic        load,
  input  logic        blank_lz,
  input  logic [7:0]  dp_en,
  output logic [7:0]  seg,
  output logic [2:0]  which,
  output logic        frame
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  logic [31:0]   shadow;
  logic [PW-1:0] pcnt;
  logic          tick;
  logic [2:0]    next_which;
  logic [3:0]    nib;
  logic [31:0]   upper;
  logic          blank;
  logic [7:0]    glyph;
  logic [7:0]    next_seg;

  assign tick       = (pcnt == PMAX);
  assign next_which = which + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // The digit about to be shown is encoded from the current shadow, so a load on a tick edge lands one tick later.
  always_comb begin
    nib   = shadow[{next_which, 2'b00} +: 4];
    upper = shadow >> {next_which, 2'b00};
    blank = blank_lz && (next_which != 3'd0) && (upper == 32'd0);
    case (nib)
      4'h0: glyph = 8'hC0;
      4'h1: glyph = 8'hF9;
      4'h2: glyph = 8'hA4;
      4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99;
      4'h5: glyph = 8'h92;
      4'h6: glyph = 8'h82;
      4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80;
      4'h9: glyph = 8'h90;
      4'hA: glyph = 8'h88;
      4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6;
      4'hD: glyph = 8'hA1;
      4'hE: glyph = 8'h86;
      default: glyph = 8'h8E;
    endcase
    if (blank) begin
      next_seg = 8'hFF;
    end else begin
      next_seg = {~dp_en[next_which], glyph[6:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      which <= 3'd0;
      seg   <= 8'hC0;
      frame <= 1'b0;
    end else if (tick) begin
      which <= next_which;
      seg   <= next_seg;
      frame <= (which == 3'd7);
    end else begin
      frame <= 1'b0;
    end
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed eight-digit hex display driver that sits directly downstream of the multi-function ALU. It captures the 32-bit ALU result on a load strobe and scans it onto a common-anode seven-segment display, one digit at a time. Each digit is selected by `which` and drawn through `seg`. It adds optional leading-zero blanking, per-digit decimal points and a frame-complete pulse.

## Interface
- `DIV`, default 16: clock cycles each digit is held. Must be ≥ 2. The prescaler is $clog2(DIV) bits wide.
- `clk` input 1: single system clock. All state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `data` input 32: value to display, normally the ALU result register.
- `load` input 1: on a rising edge with `load`=1, `data` is captured into the shadow register.
- `blank_lz` input 1: 1 enables leading-zero blanking.
- `dp_en` input 8: bit i lights the decimal point of digit i.
- `seg` output 8: {dp,g,f,e,d,c,b,a}, active-low, registered.
- `which` output 3: index of the digit currently driven. 0 is the least-significant nibble. Registered.
- `frame` output 1: one-cycle pulse when `which` wraps from 7 to 0. Registered.

## Operation
- Shadow register `shadow[31:0]`:
  - Loaded when `load`=1; otherwise holds.
  - The display always draws from `shadow`, never directly from `data`.
- Prescaler `pcnt`:
  - Counts 0..DIV-1 and wraps to 0.
  - The cycle where `pcnt`==DIV-1 is a tick.
- On a tick, these update at the same edge:
  - `which` <= `which`+1, mod 8 (7 wraps to 0).
  - `seg` <= enc(next digit).
  - `frame` <= 1 if `which` was 7, else 0.
- Off-tick: `seg` and `which` hold, and `frame` <= 0.
- enc(i), for nibble n = `shadow[4i+3:4i]`:
  - Blank (8'hFF, dp off) if `blank_lz`=1, i≠0, and nibbles i..7 are all zero.
  - Otherwise the hex glyph for n, with bit7 = ~`dp_en[i]`.
- Hex glyphs (dp bit =1), 0 through F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- Digit 0 is never blanked, so a zero value shows "0".
- Load and tick in the same cycle: the tick encodes from the old `shadow`. The new value first appears at the following tick.
- Changes to `blank_lz` and `dp_en` take effect at the next tick only.

## Timing
- Reset values, applied immediately while `rst_n`=0 and independent of `clk`:
  - `shadow`=0, `pcnt`=0, `which`=0, `frame`=0.
  - `seg`=8'hC0 (glyph 0, dp off), regardless of `dp_en`.
- After reset release, the first tick occurs at the DIV-th rising edge, moving `which` to 1.
- Each digit is held exactly DIV cycles; a full frame is 8·DIV cycles.
- `frame` is high for exactly one cycle per frame, coincident with `which` becoming 0.
- The first `frame` after reset occurs 8·DIV edges after release.
- Load-to-display latency: the captured value reaches `seg` at the next tick, between 1 and DIV cycles later. A given digit shows it within 8·DIV cycles.
- `seg` and `which` always change on the same edge, so there is no cycle where they disagree.
- Reset asserted mid-frame:
  - All state clears at once.
  - Scanning restarts from digit 0 with a full DIV hold after release.
  - A pending load in the reset cycle is discarded.

## Test plan
- Reset and hold:
  - Hold `rst_n`=0 for 100 cycles with `data`=FFFFFFFF and `load`=1 → `seg`=C0, `which`=0, `frame`=0 throughout.
  - After release with `load`=0 → every digit shows C0.
- Plain scan, DIV=4, `blank_lz`=0: load 00000008 (the 5+3 result) →
  - `which` steps 0..7, 4 cycles each.
  - Digit 0 `seg`=80, digits 1–7 `seg`=C0.
  - `frame` pulses once every 32 cycles.
- Blanking: `blank_lz`=1, load 0000012F → digits 0,1,2 = 8E, A4, F9; digits 3–7 = FF.
  - Then load 00000000 → digit 0 = C0, digits 1–7 = FF.
- Mid-digit load: while `which`=3 showing 00000000, load 89ABCDEF →
  - Digit 3 stays C0 until the tick.
  - Digit 4 then shows 83, followed by digits 5–7 = 88, 90, 80.
  - On the next frame, digits 0–3 = 8E, 86, A1, C6.
- Load coincident with tick: assert `load` in the cycle `pcnt`=DIV-1 → the next digit encodes the old value; the new value appears one tick later.
- Decimal point and async reset:
  - With `dp_en`=01 and value 0 → digit 0 `seg`=40.
  - Assert `rst_n`=0 between clock edges while `which`=5 → outputs go to C0/0/0 without a clock edge.
  - After release, the first tick comes DIV cycles later.
